// File: rtl/nios_onchip_mem_streamer.sv
// Read-side DMA: walks a word range of the on-chip memory and emits it as an Avalon-ST packet.
// Define NIOS_MEM_STREAMER_CHECKSUM_EN to add the per-transfer checksum output.
module nios_onchip_mem_streamer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic                src_startofpacket,
    output logic                src_endofpacket
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
   ,output logic [DATA_W-1:0]   checksum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     issued;
    logic                inflight;
    logic                inflight_sop;
    logic                inflight_eop;
    logic [1:0]          occ;
    logic [1:0]          occ_next;
    logic [DATA_W+1:0]   entry0;
    logic [DATA_W+1:0]   entry1;
    logic [DATA_W+1:0]   in_entry;
    logic [DATA_W+1:0]   head;
    logic [2:0]          credits;
    logic                buf_empty;
    logic                pop;
    logic                pop_buf;
    logic                push;
    logic                issue;
    logic                issue_sop;
    logic                issue_eop;

    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign buf_empty = (occ == 2'd0);
    assign in_entry  = {inflight_sop, inflight_eop, mem_readdata};

    // An empty buffer forwards the word arriving from memory, which removes the read-latency bubble.
    assign head      = buf_empty ? (inflight ? in_entry : '0) : entry0;
    assign src_valid = ~buf_empty | inflight;
    assign src_startofpacket = head[DATA_W+1];
    assign src_endofpacket   = head[DATA_W];
    assign src_data          = head[DATA_W-1:0];

    assign pop     = src_valid & src_ready;
    assign pop_buf = pop & ~buf_empty;
    assign push    = inflight & ~(pop & buf_empty);

    assign credits   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (credits < 3'd2);
    assign issue_sop = (issued == '0);
    assign issue_eop = (issued == len_q - 1'b1);

    assign mem_chipselect = issue;
    assign mem_address    = addr;
    assign busy           = (state != IDLE);

    always_comb begin
        occ_next = occ;
        if (push && !pop_buf) begin
            occ_next = occ + 2'd1;
        end else if (!push && pop_buf) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= '0;
            len_q        <= '0;
            issued       <= '0;
            done         <= 1'b0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_sop <= issue_sop;
                inflight_eop <= issue_eop;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state  <= RUN;
                            addr   <= base_addr;
                            len_q  <= length;
                            issued <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr   <= addr + 1'b1;
                        issued <= issued + 1'b1;
                        if (issued + 1'b1 == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (occ_next == 2'd0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO with entry0 as head; the credit rule keeps occupancy at or below two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            occ <= occ_next;
            case (occ)
                2'd0: begin
                    if (push) entry0 <= in_entry;
                end
                2'd1: begin
                    if (push) begin
                        if (pop_buf) entry0 <= in_entry;
                        else         entry1 <= in_entry;
                    end
                end
                default: begin
                    if (pop_buf) begin
                        entry0 <= entry1;
                        if (push) entry1 <= in_entry;
                    end
                end
            endcase
        end
    end

`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + src_data;
        end
    end
`endif

endmodule

// File: tb/tb_nios_onchip_mem_streamer.sv
// Scoreboard bench for nios_onchip_mem_streamer with a one-cycle-latency memory model.
module tb_nios_onchip_mem_streamer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     length;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_ready;
    logic                src_startofpacket;
    logic                src_endofpacket;
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W+1:0]   exp_q [$];
    int                  checks = 0;
    int                  errors = 0;

    nios_onchip_mem_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_byteenable    (mem_byteenable),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket)
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
       ,.checksum          (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: address sampled on the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    task automatic test_reset;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        src_ready = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_chipselect, mem_address, src_valid, src_data,
             src_startofpacket, src_endofpacket} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got busy=%b done=%b cs=%b addr=%h valid=%b data=%h sop=%b eop=%b, expected all zero",
                     busy, done, mem_chipselect, mem_address, src_valid, src_data, src_startofpacket, src_endofpacket);
        end
        checks++;
        if ({mem_write, mem_byteenable, mem_clken} !== {1'b0, 4'hF, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mem_constants: got write=%b be=%h clken=%b, expected 0 f 1",
                     mem_write, mem_byteenable, mem_clken);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // mode 0: src_ready held high; mode 1: src_ready pattern 1,0,0,1 repeating.
    task automatic run_transfer(input string name, input int base, input int len,
                                input int mode, input bit mid_start);
        int                n;
        int                done_cnt;
        int                done_at;
        int                first_pop;
        int                issued;
        int                accepted;
        logic [DATA_W+1:0] exp_w;
        logic [DATA_W+1:0] got_w;
        logic [DATA_W+1:0] held_w;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_sum;
        logic [DATA_W-1:0] cs_at_done;
        logic              held;
        logic              busy_at_done;

        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            exp_w = {i == 0, i == len - 1, mem[(base + i) % DEPTH]};
            exp_q.push_back(exp_w);
            exp_sum = exp_sum + mem[(base + i) % DEPTH];
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = base[ADDR_W-1:0];
        length    = len[ADDR_W:0];
        src_ready = 1'b1;
        @(negedge clk);

        n = 1; done_cnt = 0; done_at = -1; first_pop = -1;
        issued = 0; accepted = 0; held = 1'b0; held_w = '0;
        cs_at_done = '0; busy_at_done = 1'b1;
        while (n <= 300 && !(done_cnt > 0 && n > done_at + 3)) begin
            start = 1'b0;
            if (mid_start && n == 5) begin
                start     = 1'b1;
                base_addr = 13'h0100;
                length    = 14'd3;
            end
            src_ready = (mode == 0) ? 1'b1 : (((n - 1) % 4 == 0) || ((n - 1) % 4 == 3));
            #1;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || mem_chipselect !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s first_cycle: got busy=%b cs=%b, expected 1 1", name, busy, mem_chipselect);
                end
            end
            if (mem_chipselect === 1'b1) begin
                exp_addr = ADDR_W'((base + issued) % DEPTH);
                checks++;
                if (issued >= len || mem_address !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL %s read_addr: got %h (issue %0d), expected %h of %0d reads",
                             name, mem_address, issued, exp_addr, len);
                end
                issued++;
            end
            got_w = {src_startofpacket, src_endofpacket, src_data};
            if (held) begin
                checks++;
                if (src_valid !== 1'b1 || got_w !== held_w) begin
                    errors++;
                    $display("[TB] FAIL %s stall_hold: got valid=%b word=%h, expected valid=1 word=%h",
                             name, src_valid, got_w, held_w);
                end
            end
            if (src_valid === 1'b1 && src_ready) begin
                if (first_pop < 0) first_pop = n;
                accepted++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s extra_word: got %h, expected no more words", name, got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("[TB] FAIL %s word_%0d: got sop/eop/data %h, expected %h", name, accepted - 1, got_w, exp_w);
                    end
                end
            end
            held   = (src_valid === 1'b1) && !src_ready;
            held_w = got_w;
            if (issued - accepted > 2) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s outstanding: got %0d reads beyond accepted, expected at most 2", name, issued - accepted);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = n;
                    busy_at_done = busy;
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
                    cs_at_done = checksum;
`endif
                end
            end
            @(negedge clk);
            n++;
        end

        checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: got %0d pulses busy_at_done=%b, expected 1 pulse busy=0", name, done_cnt, busy_at_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_words: got %0d words still expected, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        if (mode == 0) begin
            checks++;
            if (done_at != len + 2 || first_pop != 2) begin
                errors++;
                $display("[TB] FAIL %s timing: got first word cycle %0d done cycle %0d, expected 2 and %0d",
                         name, first_pop, done_at, len + 2);
            end
        end
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
        checks++;
        if (cs_at_done !== exp_sum) begin
            errors++;
            $display("[TB] FAIL %s checksum: got %h, expected %h", name, cs_at_done, exp_sum);
        end
`else
        if (cs_at_done !== '0 || exp_sum === 'x) $display("[TB] note %s: unexpected scratch state", name);
`endif
    endtask

    task automatic test_basic;
        run_transfer("basic", 'h0010, 4, 0, 1'b0);
    endtask

    task automatic test_wrap;
        run_transfer("wrap", 'h1FFE, 4, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_transfer("backpressure", 'h0040, 8, 1, 1'b0);
    endtask

    task automatic test_length_one;
        run_transfer("len1", 'h0077, 1, 0, 1'b0);
    endtask

    task automatic test_mid_start;
        run_transfer("mid_start", 'h0300, 16, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_transfer("b2b_a", 'h0500, 5, 0, 1'b0);
        run_transfer("b2b_b", 'h0505, 3, 1, 1'b0);
    endtask

    task automatic test_length_zero;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 13'h0005;
        length    = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_chipselect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len0_done: got done=%b busy=%b cs=%b, expected 1 0 0", done, busy, mem_chipselect);
        end
`ifdef NIOS_MEM_STREAMER_CHECKSUM_EN
        checks++;
        if (checksum !== '0) begin
            errors++;
            $display("[TB] FAIL len0_checksum: got %h, expected 0", checksum);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || mem_chipselect !== 1'b0 || src_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL len0_quiet: got done=%b busy=%b cs=%b valid=%b, expected all 0",
                         done, busy, mem_chipselect, src_valid);
            end
        end
    endtask

    task automatic test_reset_abort;
        int                accepted;
        bit                aborted;
        logic [DATA_W+1:0] exp_w;
        logic [DATA_W+1:0] got_w;

        for (int i = 0; i < 16; i++) begin
            exp_w = {i == 0, i == 15, mem['h200 + i]};
            exp_q.push_back(exp_w);
        end
        @(negedge clk);
        start     = 1'b1;
        base_addr = 13'h0200;
        length    = 14'd16;
        src_ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        accepted = 0;
        aborted  = 1'b0;
        for (int n = 0; n < 40 && !aborted; n++) begin
            #1;
            if (src_valid === 1'b1 && accepted == 5) begin
                #2 reset_n = 1'b0;
                #1;
                checks++;
                if ({busy, done, mem_chipselect, mem_address, src_valid, src_data,
                     src_startofpacket, src_endofpacket} !== '0) begin
                    errors++;
                    $display("[TB] FAIL abort_values: got busy=%b done=%b cs=%b addr=%h valid=%b data=%h sop=%b eop=%b, expected all zero",
                             busy, done, mem_chipselect, mem_address, src_valid, src_data, src_startofpacket, src_endofpacket);
                end
                aborted = 1'b1;
            end else begin
                if (src_valid === 1'b1 && exp_q.size() != 0) begin
                    got_w = {src_startofpacket, src_endofpacket, src_data};
                    exp_w = exp_q.pop_front();
                    checks++;
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("[TB] FAIL abort_word_%0d: got %h, expected %h", accepted, got_w, exp_w);
                    end
                    accepted++;
                end
                @(negedge clk);
            end
        end
        checks++;
        if (!aborted) begin
            errors++;
            $display("[TB] FAIL abort_reached: got %0d words before timeout, expected word 5 to appear", accepted);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || src_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_quiet: got done=%b busy=%b valid=%b, expected 0 0 0", done, busy, src_valid);
            end
        end
        run_transfer("after_abort", 'h0020, 3, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = i[DATA_W-1:0];
        mem_readdata = '0;
        $display("[TB] starting");
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_length_zero;
        test_length_one;
        test_mid_start;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
